// File: rtl/freq_sweep_pkg.sv
// Shared types and next-point arithmetic for the frequency sweep sequencer.
// Arithmetic is done one bit wider than the frequency word so a carry out clamps instead of wrapping.
package freq_sweep_pkg;

  localparam int FREQ_W = 24;

  typedef logic [FREQ_W-1:0] freq_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DWELL, NEXT} state_e;

  typedef struct packed {
    freq_t fmin;
    freq_t fmax;
    freq_t fstep;
  } sweep_cfg_t;

  function automatic freq_t step_up(input freq_t cur, input freq_t stp, input freq_t lim);
    logic [FREQ_W:0] sum;
    sum = {1'b0, cur} + {1'b0, stp};
    if (sum > {1'b0, lim}) return lim;
    return sum[FREQ_W-1:0];
  endfunction

  function automatic freq_t step_dn(input freq_t cur, input freq_t stp, input freq_t lim);
    logic [FREQ_W:0] diff;
    diff = {1'b0, cur} - {1'b0, stp};
    if (diff[FREQ_W] || (diff[FREQ_W-1:0] < lim)) return lim;
    return diff[FREQ_W-1:0];
  endfunction

  function automatic logic cfg_ok(input sweep_cfg_t c);
    return (c.fstep != '0) && (c.fmin <= c.fmax);
  endfunction

endpackage

// File: rtl/freq_sweep_sched_if.sv
// Command-decoder / PWM-generator side bundle of the sweep sequencer.
// master drives configuration, strobes and fre_rdy; slave is the sequencer.
interface freq_sweep_sched_if;
  import freq_sweep_pkg::*;

  logic  cfg_valid;
  freq_t fre_min;
  freq_t fre_max;
  freq_t fre_step;
  logic  start;
  logic  stop;
  logic  mode_loop;
  freq_t fre_out;
  logic  fre_vld;
  logic  fre_rdy;
  logic  busy;
  logic  done;
  logic  cfg_err;

  modport master (
    output cfg_valid, fre_min, fre_max, fre_step, start, stop, mode_loop, fre_rdy,
    input  fre_out, fre_vld, busy, done, cfg_err
  );

  modport slave (
    input  cfg_valid, fre_min, fre_max, fre_step, start, stop, mode_loop, fre_rdy,
    output fre_out, fre_vld, busy, done, cfg_err
  );

endinterface

// File: rtl/sweep_dwell_timer.sv
// Dwell countdown: load sets DWELL_CYCLES-1, dec steps toward zero, zero_o flags expiry.
// One-cycle load latency; no backpressure.
module sweep_dwell_timer #(
  parameter int DWELL_CYCLES = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(DWELL_CYCLES - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/freq_sweep_sched.sv
// Steps fre_out min..max by step with a dwell per point; SWEEP_BIDIR_EN adds the triangle sweep.
// start->fre_vld 1 cycle; fre_out/fre_vld hold while fre_rdy is low, dwell starts at the handshake.
module freq_sweep_sched
  import freq_sweep_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000
) (
  input logic             CLK,
  input logic             RST,
  freq_sweep_sched_if.slave bus
);

  sweep_cfg_t shadow_q;
  sweep_cfg_t act_q;
  sweep_cfg_t new_cfg;
  state_e     state_q;
  freq_t      cur_q;
  freq_t      fre_out_q;
  logic       fre_vld_q;
  logic       busy_q;
  logic       done_q;
  logic       cfg_err_q;
  logic       loop_q;

  freq_t      nxt_d;
  freq_t      restart_d;
  logic       end_d;

  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_zero;

`ifdef SWEEP_BIDIR_EN
  logic       dir_dn_q;
  logic       dir_dn_d;
`endif

  assign new_cfg = '{fmin: bus.fre_min, fmax: bus.fre_max, fstep: bus.fre_step};

  assign tmr_load = (state_q == ISSUE) && bus.fre_rdy && !bus.stop;
  assign tmr_dec  = (state_q == DWELL) && !tmr_zero;

  sweep_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  always_comb begin
    nxt_d     = step_up(cur_q, act_q.fstep, act_q.fmax);
    end_d     = (cur_q == act_q.fmax);
    restart_d = act_q.fmin;
`ifdef SWEEP_BIDIR_EN
    dir_dn_d  = dir_dn_q;
    // Looping re-enters the up leg above min so the lower turn point is not issued twice.
    restart_d = step_up(act_q.fmin, act_q.fstep, act_q.fmax);
    if (dir_dn_q) begin
      nxt_d = step_dn(cur_q, act_q.fstep, act_q.fmin);
      end_d = (cur_q == act_q.fmin);
    end else if (end_d && (act_q.fmin != act_q.fmax)) begin
      nxt_d    = step_dn(cur_q, act_q.fstep, act_q.fmin);
      end_d    = 1'b0;
      dir_dn_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_q  <= '0;
      act_q     <= '0;
      state_q   <= IDLE;
      cur_q     <= '0;
      fre_out_q <= '0;
      fre_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      loop_q    <= 1'b0;
`ifdef SWEEP_BIDIR_EN
      dir_dn_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.cfg_valid) shadow_q <= new_cfg;
      if (bus.stop) begin
        state_q   <= IDLE;
        fre_vld_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              act_q  <= shadow_q;
              loop_q <= bus.mode_loop;
              if (cfg_ok(shadow_q)) begin
                cfg_err_q <= 1'b0;
                cur_q     <= shadow_q.fmin;
                fre_out_q <= shadow_q.fmin;
                fre_vld_q <= 1'b1;
                busy_q    <= 1'b1;
                state_q   <= ISSUE;
`ifdef SWEEP_BIDIR_EN
                dir_dn_q  <= 1'b0;
`endif
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (bus.fre_rdy) begin
              fre_vld_q <= 1'b0;
              state_q   <= DWELL;
            end
          end
          DWELL: begin
            if (tmr_zero) state_q <= NEXT;
          end
          NEXT: begin
            if (!end_d) begin
              cur_q     <= nxt_d;
              fre_out_q <= nxt_d;
              fre_vld_q <= 1'b1;
              state_q   <= ISSUE;
`ifdef SWEEP_BIDIR_EN
              dir_dn_q  <= dir_dn_d;
`endif
            end else if (loop_q) begin
              cur_q     <= restart_d;
              fre_out_q <= restart_d;
              fre_vld_q <= 1'b1;
              state_q   <= ISSUE;
`ifdef SWEEP_BIDIR_EN
              dir_dn_q  <= 1'b0;
`endif
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.fre_out = fre_out_q;
  assign bus.fre_vld = fre_vld_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_freq_sweep_sched.sv
// Directed bench for freq_sweep_sched with a 4-cycle dwell; expectations follow SWEEP_BIDIR_EN when defined.
module tb_freq_sweep_sched;
  import freq_sweep_pkg::*;

  localparam int DW = 4;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  freq_t pts[$];
  int    gaps[$];
  freq_t exp_q[$];
  logic  got_done;
  logic  done_busy;

  freq_sweep_sched_if bus ();

  freq_sweep_sched #(.DWELL_CYCLES(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input freq_t mn, input freq_t mx, input freq_t st);
    bus.fre_min   = mn;
    bus.fre_max   = mx;
    bus.fre_step  = st;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_start(input logic lp);
    bus.start     = 1'b1;
    bus.mode_loop = lp;
    tick();
    bus.start     = 1'b0;
  endtask

  // Records accepted points and the number of fre_vld-low cycles between handshakes.
  task automatic run_sweep(input int budget, input int npts_max);
    int gap;
    pts.delete();
    gaps.delete();
    got_done  = 1'b0;
    done_busy = 1'bx;
    gap       = -1;
    for (int c = 0; c < budget; c++) begin
      if (bus.fre_vld && bus.fre_rdy) begin
        pts.push_back(bus.fre_out);
        if (gap >= 0) gaps.push_back(gap);
        gap = 0;
      end else if (!bus.fre_vld && gap >= 0) begin
        gap++;
      end
      if (bus.done) begin
        got_done  = 1'b1;
        done_busy = bus.busy;
        break;
      end
      if (npts_max > 0 && pts.size() == npts_max) break;
      tick();
    end
  endtask

  task automatic check_pts(input string tag);
    chk({tag, "_count"}, pts.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("%s_pt%0d", tag, i), (i < pts.size()) ? 32'(pts[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
    foreach (gaps[i])
      chk($sformatf("%s_gap%0d", tag, i), gaps[i], DW + 1);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done_seen"}, got_done, 1'b1);
    chk({tag, "_busy_at_done"}, done_busy, 1'b0);
    tick();
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    logic seen;
    total = 0;
    bad   = 0;
    RST           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.fre_min   = '0;
    bus.fre_max   = '0;
    bus.fre_step  = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode_loop = 1'b0;
    bus.fre_rdy   = 1'b1;
    tick();
    tick();

    chk("rst_fre_out", bus.fre_out, 0);
    chk("rst_fre_vld", bus.fre_vld, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    RST = 1'b0;
    tick();

    // Basic one-shot ascending sweep
    load_cfg(24'd100, 24'd130, 24'd10);
    do_start(1'b0);
    chk("start_vld", bus.fre_vld, 1);
    chk("start_out", bus.fre_out, 100);
    chk("start_busy", bus.busy, 1);
    run_sweep(200, 0);
`ifdef SWEEP_BIDIR_EN
    exp_q = '{24'd100, 24'd110, 24'd120, 24'd130, 24'd120, 24'd110, 24'd100};
`else
    exp_q = '{24'd100, 24'd110, 24'd120, 24'd130};
`endif
    check_pts("basic");
    check_done("basic");

    // Clamp of the final point to max
    load_cfg(24'd100, 24'd130, 24'd25);
    do_start(1'b0);
    run_sweep(200, 0);
`ifdef SWEEP_BIDIR_EN
    exp_q = '{24'd100, 24'd125, 24'd130, 24'd105, 24'd100};
`else
    exp_q = '{24'd100, 24'd125, 24'd130};
`endif
    check_pts("clamp");
    check_done("clamp");

    // Carry out of the frequency word clamps to max
    load_cfg(24'hFFFFF0, 24'hFFFFFF, 24'd20);
    do_start(1'b0);
    run_sweep(200, 0);
`ifdef SWEEP_BIDIR_EN
    exp_q = '{24'hFFFFF0, 24'hFFFFFF, 24'hFFFFF0};
`else
    exp_q = '{24'hFFFFF0, 24'hFFFFFF};
`endif
    check_pts("carry");
    check_done("carry");

    // Invalid configurations
    load_cfg(24'd100, 24'd130, 24'd0);
    do_start(1'b0);
    chk("step0_err", bus.cfg_err, 1);
    chk("step0_vld", bus.fre_vld, 0);
    chk("step0_busy", bus.busy, 0);
    load_cfg(24'd200, 24'd100, 24'd10);
    do_start(1'b0);
    chk("minmax_err", bus.cfg_err, 1);
    chk("minmax_vld", bus.fre_vld, 0);
    tick();
    chk("minmax_err_hold", bus.cfg_err, 1);

    // Valid single-point sweep clears the error
    load_cfg(24'd100, 24'd100, 24'd10);
    do_start(1'b0);
    chk("single_err_clr", bus.cfg_err, 0);
    run_sweep(200, 0);
    exp_q = '{24'd100};
    check_pts("single");
    check_done("single");

    // Stall in ISSUE plus a mid-sweep reconfiguration
    load_cfg(24'd100, 24'd130, 24'd10);
    bus.fre_rdy = 1'b0;
    do_start(1'b0);
    bus.fre_min   = 24'd500;
    bus.fre_max   = 24'd600;
    bus.fre_step  = 24'd50;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    tick();
    chk("stall_vld", bus.fre_vld, 1);
    chk("stall_out", bus.fre_out, 100);
    chk("stall_busy", bus.busy, 1);
    bus.fre_rdy = 1'b1;
    run_sweep(200, 0);
`ifdef SWEEP_BIDIR_EN
    exp_q = '{24'd100, 24'd110, 24'd120, 24'd130, 24'd120, 24'd110, 24'd100};
`else
    exp_q = '{24'd100, 24'd110, 24'd120, 24'd130};
`endif
    check_pts("stall");
    check_done("stall");

    // New configuration takes effect at the next start; stop in DWELL
    do_start(1'b0);
    chk("newcfg_out", bus.fre_out, 500);
    tick();
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_busy", bus.busy, 0);
    chk("stop_vld", bus.fre_vld, 0);
    chk("stop_done", bus.done, 0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen = seen | bus.done | bus.fre_vld;
    end
    chk("stop_quiet", seen, 0);

    // start and stop together
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("startstop_busy", bus.busy, 0);
    chk("startstop_vld", bus.fre_vld, 0);

    // Reset while waiting in ISSUE
    bus.fre_rdy = 1'b0;
    do_start(1'b0);
    chk("pre_rst_vld", bus.fre_vld, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_fre_out", bus.fre_out, 0);
    chk("midrst_vld", bus.fre_vld, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_cfg_err", bus.cfg_err, 0);
    do_start(1'b0);
    chk("shadow_cleared_err", bus.cfg_err, 1);
    bus.fre_rdy = 1'b1;

    // Continuous sweep, stopped on a handshake cycle
    load_cfg(24'd100, 24'd130, 24'd10);
    do_start(1'b1);
    run_sweep(300, 10);
`ifdef SWEEP_BIDIR_EN
    exp_q = '{24'd100, 24'd110, 24'd120, 24'd130, 24'd120,
              24'd110, 24'd100, 24'd110, 24'd120, 24'd130};
`else
    exp_q = '{24'd100, 24'd110, 24'd120, 24'd130, 24'd100,
              24'd110, 24'd120, 24'd130, 24'd100, 24'd110};
`endif
    check_pts("loop");
    chk("loop_no_done", got_done, 0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("loop_stop_vld", bus.fre_vld, 0);
    chk("loop_stop_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
